cdm16_mem_responder: RTL and testbench

Memory-side responder for the CDM16 core's word-addressed memory bus. Accepts word/byte requests (15-bit word address, 2-bit byte write strobes), serves them from internal synchronous RAM plus a small memory-mapped I/O window, and stalls the core through a hold output for a configurable number of wait states. Includes a host load port for preloading program RAM while the core is held in reset.

---
 rtl/cdm16_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_cdm16_mem_responder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdm16_mem_responder.sv
// CDM16 memory-side responder: word-addressed RAM, small I/O window, wait-state stall and host loader port.
// Optional free-running cycle counter at IO_BASE+2 is built when CDM16_MEM_CYCLE_COUNTER_EN is defined.
module cdm16_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned IO_BASE     = 15'h7FF0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [14:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  input  logic        mem_en,
  input  logic [1:0]  mem_write,
  output logic        mem_hold,
  input  logic        load_en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [14:0] load_addr,
  input  logic [15:0] load_data,
  output logic [15:0] io_out,
  input  logic [15:0] io_in
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // WAIT lasts WAIT_STATES cycles, so the counter is loaded one lower and the access fires at zero.
  localparam logic [1:0] WS_LOAD = (WAIT_STATES == 0) ? 2'd0 : 2'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  wcnt, wcnt_nx;
  logic [14:0] cap_addr;
  logic [15:0] cap_wdata;
  logic [1:0]  cap_write;
  logic        start;
  logic        acc_fire;

  logic [14:0] acc_addr;
  logic [15:0] acc_wdata;
  logic [1:0]  acc_write;
  logic        is_ram;
  logic        is_io;
  logic [3:0]  io_off;
  logic        core_we;
  logic        load_we;
  logic [15:0] rd_mux;
  logic [15:0] cnt_rd;

  logic [15:0] ram [DEPTH_WORDS];

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    start    = 1'b0;
    acc_fire = 1'b0;
    mem_hold = 1'b0;
    case (state)
      ST_IDLE: begin
        mem_hold = mem_en;
        if (mem_en && !load_en) begin
          start = 1'b1;
          if (WAIT_STATES == 0) begin
            acc_fire = 1'b1;
            state_nx = ST_RESP;
          end else begin
            wcnt_nx  = WS_LOAD;
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        mem_hold = 1'b1;
        if (wcnt == 2'd0) begin
          acc_fire = 1'b1;
          state_nx = ST_RESP;
        end else begin
          wcnt_nx = wcnt - 2'd1;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // With zero wait states the access fires in IDLE, before anything has been captured.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_addr  = mem_addr;
      acc_wdata = mem_wdata;
      acc_write = mem_write;
    end else begin
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
      acc_write = cap_write;
    end
  end

  assign is_ram  = 32'(acc_addr) < DEPTH_WORDS;
  assign is_io   = !is_ram && (32'(acc_addr) >= IO_BASE) && (32'(acc_addr) < IO_BASE + 16);
  assign io_off  = 4'(acc_addr - 15'(IO_BASE));
  assign core_we = acc_fire && reset_n && (acc_write != 2'b00);

  assign load_ready = load_en && (state == ST_IDLE);
  assign load_we    = load_valid && load_ready && (32'(load_addr) < DEPTH_WORDS);

  always_comb begin
    rd_mux = '0;
    if (is_ram) begin
      rd_mux = ram[acc_addr[AW-1:0]];
    end else if (is_io) begin
      case (io_off)
        4'd0:    rd_mux = io_out;
        4'd1:    rd_mux = io_in;
        4'd2:    rd_mux = cnt_rd;
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_write <= '0;
      mem_rdata <= '0;
      io_out    <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (start) begin
        cap_addr  <= mem_addr;
        cap_wdata <= mem_wdata;
        cap_write <= mem_write;
      end
      if (acc_fire && (acc_write == 2'b00)) begin
        mem_rdata <= rd_mux;
      end
      if (core_we && is_io && (io_off == 4'd0)) begin
        if (acc_write[0]) io_out[7:0]  <= acc_wdata[7:0];
        if (acc_write[1]) io_out[15:8] <= acc_wdata[15:8];
      end
    end
  end

  // Core and loader writes are mutually exclusive: the core never starts while load_en is high.
  always_ff @(posedge clock) begin
    if (core_we && is_ram) begin
      if (acc_write[0]) ram[acc_addr[AW-1:0]][7:0]  <= acc_wdata[7:0];
      if (acc_write[1]) ram[acc_addr[AW-1:0]][15:8] <= acc_wdata[15:8];
    end else if (load_we) begin
      ram[load_addr[AW-1:0]] <= load_data;
    end
  end

`ifdef CDM16_MEM_CYCLE_COUNTER_EN
  logic [15:0] cyc_cnt;
  logic [15:0] cyc_nx;
  logic        cnt_we;

  assign cnt_we = core_we && is_io && (io_off == 4'd2);

  // Written bytes override the incremented value; unwritten bytes keep counting.
  always_comb begin
    cyc_nx = cyc_cnt + 16'd1;
    if (cnt_we) begin
      if (acc_write[0]) cyc_nx[7:0]  = acc_wdata[7:0];
      if (acc_write[1]) cyc_nx[15:8] = acc_wdata[15:8];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) cyc_cnt <= '0;
    else          cyc_cnt <= cyc_nx;
  end

  assign cnt_rd = cyc_cnt;
`else
  assign cnt_rd = '0;
`endif

endmodule

// File: tb/tb_cdm16_mem_responder.sv
// Self-checking bench for cdm16_mem_responder: directed vector table, hand-written corner sequences
// and randomized accesses checked against an arithmetic reference model.
module tb_cdm16_mem_responder;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned WS    = 1;
  localparam int unsigned IOB   = 15'h7FF0;

  logic        clock;
  logic        reset_n;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_en;
  logic [1:0]  mem_write;
  logic        mem_hold;
  logic        load_en;
  logic        load_valid;
  logic        load_ready;
  logic [14:0] load_addr;
  logic [15:0] load_data;
  logic [15:0] io_out;
  logic [15:0] io_in;

  cdm16_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS),
    .IO_BASE(IOB)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_en(mem_en),
    .mem_write(mem_write),
    .mem_hold(mem_hold),
    .load_en(load_en),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_addr(load_addr),
    .load_data(load_data),
    .io_out(io_out),
    .io_in(io_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned edges = 0;
  always @(posedge clock) edges <= edges + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  logic [15:0] ram_m [DEPTH];
  logic [15:0] io_m;
  logic [15:0] last_rd;
  logic [15:0] cnt_base;
  int unsigned cnt_edge;
  logic [15:0] obs_rd;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [1:0]  strb;
    logic [15:0] ioin;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %04h expected %04h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] s);
    return {s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
  endfunction

  // Counter value held after edge n
  function automatic logic [15:0] cnt_at(input int unsigned n);
    return 16'(32'(cnt_base) + (n - cnt_edge));
  endfunction

  // Applies an access performed at edge e to the model; returns the expected mem_rdata afterwards.
  function automatic logic [15:0] model_access(input logic [14:0] a, input logic [15:0] d,
                                               input logic [1:0] s, input logic [15:0] ioin,
                                               input int unsigned e);
    int unsigned ai;
    logic [15:0] rd;
    ai = a;
    rd = '0;
    if (ai < DEPTH) begin
      rd = ram_m[ai];
      if (s != 2'b00) ram_m[ai] = merge(ram_m[ai], d, s);
    end else if (ai >= IOB && ai < IOB + 16) begin
      case (ai - IOB)
        0: begin
          rd = io_m;
          if (s != 2'b00) io_m = merge(io_m, d, s);
        end
        1: rd = ioin;
        2: begin
`ifdef CDM16_MEM_CYCLE_COUNTER_EN
          rd = cnt_at(e - 1);
          if (s != 2'b00) begin
            cnt_base = merge(cnt_at(e - 1) + 16'd1, d, s);
            cnt_edge = e;
          end
`else
          rd = '0;
`endif
        end
        default: rd = '0;
      endcase
    end
    if (s == 2'b00) last_rd = rd;
    return last_rd;
  endfunction

  task automatic model_reset();
    io_m     = '0;
    last_rd  = '0;
    cnt_base = '0;
    cnt_edge = edges;
  endtask

  task automatic apply_reset(input int unsigned n);
    reset_n    = 1'b0;
    mem_en     = 1'b0;
    load_en    = 1'b0;
    load_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    check("rst_hold", {15'd0, mem_hold}, 16'd0);
    check("rst_rdata", mem_rdata, 16'h0000);
    check("rst_io_out", io_out, 16'h0000);
    check("rst_load_ready", {15'd0, load_ready}, 16'd0);
    model_reset();
    reset_n = 1'b1;
  endtask

  // One full core access; starts and ends 1 time unit after a rising edge with the DUT idle.
  task automatic do_access(input logic [14:0] a, input logic [15:0] d, input logic [1:0] s,
                           input logic [15:0] ioin);
    logic [15:0] exp_rd;
    io_in     = ioin;
    mem_addr  = a;
    mem_wdata = d;
    mem_write = s;
    mem_en    = 1'b1;
    #3;
    check("hold_req", {15'd0, mem_hold}, 16'd1);
    @(posedge clock);
    #1;
    mem_en    = 1'b0;
    mem_addr  = 15'($urandom);
    mem_wdata = 16'($urandom);
    mem_write = 2'($urandom);
    for (int i = 0; i < WS; i++) begin
      #3;
      check("hold_wait", {15'd0, mem_hold}, 16'd1);
      @(posedge clock);
      #1;
    end
    exp_rd = model_access(a, d, s, ioin, edges);
    #2;
    check("hold_resp", {15'd0, mem_hold}, 16'd0);
    check("rdata", mem_rdata, exp_rd);
    check("io_out", io_out, io_m);
    obs_rd = mem_rdata;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    int unsigned sel;
    logic [14:0] ra;

    reset_n    = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_write  = '0;
    load_en    = 1'b0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    io_in      = '0;

    vecs[0]  = '{15'h0010,      16'h0000, 2'b00, 16'h0000, 1'b1, 16'hBEEF};
    vecs[1]  = '{15'h0020,      16'h12AB, 2'b01, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{15'h0020,      16'hCD00, 2'b10, 16'h0000, 1'b0, 16'h0000};
    vecs[3]  = '{15'h0020,      16'h0000, 2'b00, 16'h0000, 1'b1, 16'hCDAB};
    vecs[4]  = '{15'(IOB),      16'h00A5, 2'b11, 16'h0000, 1'b0, 16'h0000};
    vecs[5]  = '{15'(IOB),      16'h0000, 2'b00, 16'h0000, 1'b1, 16'h00A5};
    vecs[6]  = '{15'(IOB + 1),  16'h0000, 2'b00, 16'h5A5A, 1'b1, 16'h5A5A};
    vecs[7]  = '{15'h5000,      16'h0000, 2'b00, 16'h0000, 1'b1, 16'h0000};
    vecs[8]  = '{15'h5000,      16'hFFFF, 2'b11, 16'h0000, 1'b0, 16'h0000};
    vecs[9]  = '{15'h5000,      16'h0000, 2'b00, 16'h0000, 1'b1, 16'h0000};
    vecs[10] = '{15'(IOB + 1),  16'hFFFF, 2'b11, 16'h0000, 1'b0, 16'h0000};
    vecs[11] = '{15'(IOB + 1),  16'h0000, 2'b00, 16'h1234, 1'b1, 16'h1234};
    vecs[12] = '{15'(IOB + 7),  16'h0000, 2'b00, 16'h0000, 1'b1, 16'h0000};
    vecs[13] = '{15'h0011,      16'h0000, 2'b00, 16'h0000, 1'b1, 16'h0B0B};

    apply_reset(3);

    // Loader preload while a core write request is held off
    load_en    = 1'b1;
    mem_en     = 1'b1;
    mem_write  = 2'b11;
    mem_addr   = 15'h0011;
    mem_wdata  = 16'hFFFF;
    load_valid = 1'b1;
    for (int i = 0; i < 65; i++) begin
      if (i == 64) begin
        load_addr = 15'h6000;
        load_data = 16'hDEAD;
      end else begin
        case (i)
          16'h10:  v = 16'hBEEF;
          16'h11:  v = 16'h0B0B;
          16'h20:  v = 16'h0000;
          16'h30:  v = 16'h2222;
          default: v = 16'($urandom);
        endcase
        load_addr = 15'(i);
        load_data = v;
        ram_m[i]  = v;
      end
      #3;
      check("load_ready", {15'd0, load_ready}, 16'd1);
      check("hold_contend", {15'd0, mem_hold}, 16'd1);
      @(posedge clock);
      #1;
    end
    load_valid = 1'b0;
    load_en    = 1'b0;
    mem_en     = 1'b0;
    #3;
    check("load_ready_off", {15'd0, load_ready}, 16'd0);
    @(posedge clock);
    #1;

    for (int i = 0; i < 14; i++) begin
      do_access(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].ioin);
      if (vecs[i].chk) check($sformatf("vec%0d", i), obs_rd, vecs[i].exp);
    end

    // Counter wrap, then a partial-strobe write
    do_access(15'(IOB + 2), 16'hFFFE, 2'b11, 16'h0000);
    do_access(15'(IOB + 2), 16'h0000, 2'b00, 16'h0000);
    check("cnt_wrap", obs_rd, 16'h0000);
    do_access(15'(IOB + 2), 16'hAB00, 2'b10, 16'h0000);
    do_access(15'(IOB + 2), 16'h0000, 2'b00, 16'h0000);

    // load_en rising during WAIT: access completes, loader waits for IDLE
    io_in     = 16'h0000;
    mem_addr  = 15'h0010;
    mem_write = 2'b00;
    mem_en    = 1'b1;
    @(posedge clock);
    #1;
    mem_en     = 1'b0;
    load_en    = 1'b1;
    load_valid = 1'b1;
    load_addr  = 15'h0015;
    load_data  = 16'h7777;
    #2;
    check("ldr_wait_ready", {15'd0, load_ready}, 16'd0);
    check("ldr_wait_hold", {15'd0, mem_hold}, 16'd1);
    @(posedge clock);
    #1;
    v = model_access(15'h0010, 16'h0000, 2'b00, 16'h0000, edges);
    #2;
    check("ldr_resp_ready", {15'd0, load_ready}, 16'd0);
    check("ldr_resp_rdata", mem_rdata, v);
    check("ldr_resp_beef", mem_rdata, 16'hBEEF);
    @(posedge clock);
    #1;
    check("ldr_idle_ready", {15'd0, load_ready}, 16'd1);
    @(posedge clock);
    #1;
    ram_m[16'h15] = 16'h7777;
    load_en    = 1'b0;
    load_valid = 1'b0;
    do_access(15'h0015, 16'h0000, 2'b00, 16'h0000);
    check("ldr_word", obs_rd, 16'h7777);

    // Reset in the middle of a write
    do_access(15'(IOB), 16'h00A5, 2'b11, 16'h0000);
    do_access(15'h0010, 16'h0000, 2'b00, 16'h0000);
    mem_addr  = 15'h0030;
    mem_wdata = 16'h1111;
    mem_write = 2'b11;
    mem_en    = 1'b1;
    @(posedge clock);
    #1;
    mem_en = 1'b0;
    #2;
    check("midrst_hold", {15'd0, mem_hold}, 16'd1);
    apply_reset(1);
    do_access(15'h0030, 16'h0000, 2'b00, 16'h0000);
    check("midrst_ram", obs_rd, 16'h2222);

    // Randomized accesses against the model
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0, 1:    ra = 15'($urandom_range(0, 63));
        2:       ra = 15'(IOB + $urandom_range(0, 15));
        default: ra = 15'($urandom_range(DEPTH, IOB - 1));
      endcase
      do_access(ra, 16'($urandom), 2'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
